usb_tx_sched: RTL and testbench
===============================

# usb_tx_sched

Transmit-side scheduler for the USB 2.0 device stack. It arbitrates between the token/handshake source and the data-packet source, then drives the `o_tx_data_on` select into the transmit control mux. It sequences every packet through grant, completion and inter-packet gap, and aborts stalled or cancelled data packets. It sits between the protocol engine's request lines and the transmit mux in front of the link/packet layer.

## Interface
- `IPG_CYCLES`, default 8: idle cycles inserted after every packet; 0 means no gap.
- `TIMEOUT_CYCLES`, default 1024: maximum consecutive cycles in DATA without a data beat before abort.
- `TOK_BURST`, default 4: maximum consecutive token grants while a data request is pending.
- `i_control_t_clk`  in  1  clock.
- `i_control_t_rst_n`  in  1  reset; asynchronous, active-low.
- `i_to_req`  in  1  token source has a packet pending (level).
- `i_lt_req`  in  1  data source has a packet pending (level).
- `i_to_valid`  in  1  token stream valid.
- `i_to_eop`  in  1  token stream end-of-packet.
- `i_lt_valid`  in  1  data stream valid.
- `i_lp_ready`  in  1  packet layer ready.
- `i_lt_cancle`  in  1  data source cancel request.
- `i_lp_eop_en`  in  1  data packet end accepted (from the mux).
- `o_tx_data_on`  out  1  mux select; 1 = data path.
- `o_to_grant`  out  1  token source owns the transmitter.
- `o_lt_grant`  out  1  data source owns the transmitter.
- `o_busy`  out  1  state is not IDLE.
- `o_state`  out  3  current state code, for debug.
- `o_timeout`  out  1  one-cycle pulse when the watchdog fires.
- `o_abort`  out  1  one-cycle pulse on entry to FLUSH (cancel or timeout).

## Operation
- States and codes: IDLE=0, TOKEN=1, DATA=2, FLUSH=3, GAP=4. Codes 5–7 are illegal and recover to IDLE.
- IDLE
  - Requests are sampled only in IDLE.
  - `i_to_req` → TOKEN. Otherwise `i_lt_req` → DATA.
  - Starvation guard: if both requests are asserted and `burst_cnt == TOK_BURST`, DATA wins.
- Burst counter
  - Increments, saturating, on each TOKEN grant made while `i_lt_req`=1.
  - Clears on any DATA grant.
- TOKEN
  - `o_to_grant`=1, `o_tx_data_on`=0.
  - Completes on `i_to_valid & i_to_eop` → GAP.
- DATA
  - `o_lt_grant`=1, `o_tx_data_on`=1.
  - `i_lt_cancle` → FLUSH.
  - Else `i_lp_eop_en` → GAP.
  - Else watchdog reaches `TIMEOUT_CYCLES` → FLUSH, with `o_timeout` pulsed.
- Watchdog
  - Clears on entry to DATA and on every beat (`i_lt_valid & i_lp_ready`).
  - Otherwise increments.
- FLUSH
  - Lasts 1 cycle. `o_tx_data_on` stays 1 so the cancel propagates; grants are 0.
  - Then → GAP.
- GAP
  - Grants are 0 and `o_tx_data_on`=0.
  - Gap counter loads `IPG_CYCLES-1` on entry and decrements; at 0 → IDLE.
  - If `IPG_CYCLES`=0, completion goes directly to IDLE.
- Requests that drop while granted are ignored; the grant holds until completion, cancel or timeout.
- Width rules
  - Gap counter: `$clog2(IPG_CYCLES+1)` bits.
  - Watchdog: `$clog2(TIMEOUT_CYCLES+1)` bits.
  - Burst counter: `$clog2(TOK_BURST+1)` bits.
  - All counters are unsigned and never wrap.

## Timing
- All outputs are registered.
- Reset values: state IDLE; all outputs 0, `o_state`=0; all counters 0.
- Reset asserted mid-packet forces IDLE asynchronously and drops grants and `o_tx_data_on` immediately.
- Grant latency: a request sampled in IDLE at cycle N gives grant and select at N+1.
- Completion latency: a completion condition at cycle N puts the block in GAP at N+1 and IDLE at N+1+`IPG_CYCLES`.
- Minimum spacing: IDLE lasts at least 1 cycle, so the next grant comes no earlier than completion + `IPG_CYCLES` + 2.
- Simultaneous events in DATA: cancel beats `i_lp_eop_en`, which beats timeout.
- `i_lt_cancle` outside DATA is ignored.
- `o_timeout` and `o_abort` pulse in the same cycle as the FLUSH entry, i.e. the cycle after the causing condition is sampled.

## Structure
- Shared package `usb_tx_sched_pkg` holds:
  - the state encodings;
  - the default values of `IPG_CYCLES`, `TIMEOUT_CYCLES` and `TOK_BURST`.
- One sub-module, `usb_tx_timer`: parameterised loadable down/up counter with a terminal-count flag.
  - Instantiated twice: once for the gap counter, once for the watchdog.
- Arbitration and the FSM stay in `usb_tx_sched`.

## Test plan
- **Reset:** assert `rst_n`=0 mid-DATA → all outputs 0 within the same cycle; after release, IDLE with `o_state`=0.
- **Token then data:** with `IPG_CYCLES`=8, `i_to_req` and `i_lt_req` both high at cycle 10 → `o_to_grant` at cycle 11. Token eop at cycle 14 → GAP cycles 15–22, IDLE at 23, `o_lt_grant` and `o_tx_data_on` at 24.
- **Starvation:** `TOK_BURST`=4, both requests held continuously → grant order is T,T,T,T,D,T,T,T,T,D.
- **Cancel:** `i_lt_cancle` and `i_lp_eop_en` asserted together in DATA → FLUSH for 1 cycle with `o_abort`=1 and `o_tx_data_on`=1, then GAP.
- **Timeout:** `TIMEOUT_CYCLES`=16, DATA with `i_lp_ready`=0 → `o_timeout` and `o_abort` pulse 17 cycles after grant. One beat at cycle 10 restarts the count.
- **Zero gap:** `IPG_CYCLES`=0, token eop at cycle N → IDLE at N+1, next grant at N+2.

Source files
------------

// File: rtl/usb_tx_sched_pkg.sv
// Shared definitions for the USB transmit scheduler: state encodings,
// parameter defaults and the counter-width helper.
package usb_tx_sched_pkg;

  typedef enum logic [2:0] {
    ST_IDLE  = 3'd0,
    ST_TOKEN = 3'd1,
    ST_DATA  = 3'd2,
    ST_FLUSH = 3'd3,
    ST_GAP   = 3'd4
  } state_e;

  localparam int IPG_CYCLES_DEF     = 8;
  localparam int TIMEOUT_CYCLES_DEF = 1024;
  localparam int TOK_BURST_DEF      = 4;

  // Bits needed to hold 0..n; a zero-sized counter still gets one bit.
  function automatic int cnt_w(input int n);
    return (n > 0) ? $clog2(n + 1) : 1;
  endfunction

endpackage

// File: rtl/usb_tx_timer.sv
// Loadable saturating counter (up or down) with a terminal-count flag.
// Used for the inter-packet gap and the DATA watchdog.
module usb_tx_timer #(
  parameter int W      = 4,
  parameter bit UP     = 1'b0,
  parameter int TC_VAL = 0
) (
  input  logic         i_control_t_clk,
  input  logic         i_control_t_rst_n,
  input  logic         load_i,
  input  logic [W-1:0] load_val_i,
  input  logic         en_i,
  output logic         tc_o
);

  logic [W-1:0] cnt_q, cnt_d;

  always_comb begin
    cnt_d = cnt_q;
    if (load_i) begin
      cnt_d = load_val_i;
    end else if (en_i) begin
      if (UP) begin
        if (cnt_q != {W{1'b1}}) cnt_d = cnt_q + W'(1);
      end else begin
        if (cnt_q != '0) cnt_d = cnt_q - W'(1);
      end
    end
  end

  always_ff @(posedge i_control_t_clk or negedge i_control_t_rst_n) begin
    if (!i_control_t_rst_n) cnt_q <= '0;
    else                    cnt_q <= cnt_d;
  end

  assign tc_o = (cnt_q == W'(TC_VAL));

endmodule

// File: rtl/usb_tx_sched.sv
// Transmit scheduler: arbitrates token vs data sources, sequences each packet
// through grant, completion, optional flush and inter-packet gap.
module usb_tx_sched
  import usb_tx_sched_pkg::*;
#(
  parameter int IPG_CYCLES     = IPG_CYCLES_DEF,
  parameter int TIMEOUT_CYCLES = TIMEOUT_CYCLES_DEF,
  parameter int TOK_BURST      = TOK_BURST_DEF
) (
  input  logic       i_control_t_clk,
  input  logic       i_control_t_rst_n,
  input  logic       i_to_req,
  input  logic       i_lt_req,
  input  logic       i_to_valid,
  input  logic       i_to_eop,
  input  logic       i_lt_valid,
  input  logic       i_lp_ready,
  input  logic       i_lt_cancle,
  input  logic       i_lp_eop_en,
  output logic       o_tx_data_on,
  output logic       o_to_grant,
  output logic       o_lt_grant,
  output logic       o_busy,
  output logic [2:0] o_state,
  output logic       o_timeout,
  output logic       o_abort
);

  localparam int GAP_W = cnt_w(IPG_CYCLES);
  localparam int WD_W  = cnt_w(TIMEOUT_CYCLES);
  localparam int BST_W = cnt_w(TOK_BURST);
  localparam logic [GAP_W-1:0] GAP_LOAD = (IPG_CYCLES > 0) ? GAP_W'(IPG_CYCLES - 1) : '0;
  localparam logic [BST_W-1:0] BST_MAX  = BST_W'(TOK_BURST);
  // With no gap configured, packet completion returns straight to IDLE.
  localparam state_e DONE_ST = (IPG_CYCLES > 0) ? ST_GAP : ST_IDLE;

  state_e           state_q, state_d;
  logic [BST_W-1:0] burst_q, burst_d;
  logic             gap_tc, wd_tc, wd_fire, beat;
  logic             data_on_d, to_grant_d, lt_grant_d, busy_d, timeout_d, abort_d;
  logic             data_on_q, to_grant_q, lt_grant_q, busy_q, timeout_q, abort_q;

  assign beat = i_lt_valid & i_lp_ready;

  always_ff @(posedge i_control_t_clk or negedge i_control_t_rst_n) begin
    if (!i_control_t_rst_n) state_q <= ST_IDLE;
    else                    state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    wd_fire = 1'b0;
    case (state_q)
      ST_IDLE: begin
        // Starvation guard: a full token burst hands the next slot to data.
        if (i_to_req && !(i_lt_req && burst_q == BST_MAX)) state_d = ST_TOKEN;
        else if (i_lt_req)                                 state_d = ST_DATA;
      end
      ST_TOKEN: if (i_to_valid && i_to_eop) state_d = DONE_ST;
      ST_DATA: begin
        if (i_lt_cancle)      state_d = ST_FLUSH;
        else if (i_lp_eop_en) state_d = DONE_ST;
        else if (wd_tc) begin
          state_d = ST_FLUSH;
          wd_fire = 1'b1;
        end
      end
      ST_FLUSH: state_d = DONE_ST;
      ST_GAP:   if (gap_tc) state_d = ST_IDLE;
      default:  state_d = ST_IDLE;
    endcase
  end

  always_comb begin
    to_grant_d = (state_d == ST_TOKEN);
    lt_grant_d = (state_d == ST_DATA);
    data_on_d  = (state_d == ST_DATA) || (state_d == ST_FLUSH);
    busy_d     = (state_d != ST_IDLE);
    timeout_d  = wd_fire;
    abort_d    = (state_q == ST_DATA) && (state_d == ST_FLUSH);
  end

  always_ff @(posedge i_control_t_clk or negedge i_control_t_rst_n) begin
    if (!i_control_t_rst_n) begin
      data_on_q  <= 1'b0;
      to_grant_q <= 1'b0;
      lt_grant_q <= 1'b0;
      busy_q     <= 1'b0;
      timeout_q  <= 1'b0;
      abort_q    <= 1'b0;
    end else begin
      data_on_q  <= data_on_d;
      to_grant_q <= to_grant_d;
      lt_grant_q <= lt_grant_d;
      busy_q     <= busy_d;
      timeout_q  <= timeout_d;
      abort_q    <= abort_d;
    end
  end

  always_comb begin
    burst_d = burst_q;
    if (state_q == ST_IDLE && state_d == ST_TOKEN && i_lt_req && burst_q != BST_MAX)
      burst_d = burst_q + BST_W'(1);
    else if (state_q == ST_IDLE && state_d == ST_DATA)
      burst_d = '0;
  end

  always_ff @(posedge i_control_t_clk or negedge i_control_t_rst_n) begin
    if (!i_control_t_rst_n) burst_q <= '0;
    else                    burst_q <= burst_d;
  end

  usb_tx_timer #(.W(GAP_W), .UP(1'b0), .TC_VAL(0)) u_gap (
    .i_control_t_clk   (i_control_t_clk),
    .i_control_t_rst_n (i_control_t_rst_n),
    .load_i            ((state_d == ST_GAP) && (state_q != ST_GAP)),
    .load_val_i        (GAP_LOAD),
    .en_i              (state_q == ST_GAP),
    .tc_o              (gap_tc)
  );

  // Watchdog restarts on DATA entry and on every accepted beat.
  usb_tx_timer #(.W(WD_W), .UP(1'b1), .TC_VAL(TIMEOUT_CYCLES)) u_wdog (
    .i_control_t_clk   (i_control_t_clk),
    .i_control_t_rst_n (i_control_t_rst_n),
    .load_i            (((state_d == ST_DATA) && (state_q != ST_DATA)) ||
                        ((state_q == ST_DATA) && beat)),
    .load_val_i        ('0),
    .en_i              (state_q == ST_DATA),
    .tc_o              (wd_tc)
  );

  assign o_tx_data_on = data_on_q;
  assign o_to_grant   = to_grant_q;
  assign o_lt_grant   = lt_grant_q;
  assign o_busy       = busy_q;
  assign o_state      = state_q;
  assign o_timeout    = timeout_q;
  assign o_abort      = abort_q;

endmodule

// File: tb/tb_usb_tx_sched.sv
// Directed bench for usb_tx_sched: per-cycle vector table plus sequences for
// starvation, watchdog, zero gap and asynchronous reset.
module tb_usb_tx_sched;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  logic to_req = 0, lt_req = 0, to_valid = 0, to_eop = 0;
  logic lt_valid = 0, lp_ready = 0, cancel = 0, eop_en = 0;
  logic tx_on, to_g, lt_g, busy, tmo, abt;
  logic [2:0] st;

  logic z_to_req = 0, z_to_valid = 0, z_to_eop = 0;
  logic z_tx_on, z_to_g, z_lt_g, z_busy, z_tmo, z_abt;
  logic [2:0] z_st;

  usb_tx_sched #(.IPG_CYCLES(8), .TIMEOUT_CYCLES(16), .TOK_BURST(4)) dut (
    .i_control_t_clk(clk), .i_control_t_rst_n(rst_n),
    .i_to_req(to_req), .i_lt_req(lt_req), .i_to_valid(to_valid), .i_to_eop(to_eop),
    .i_lt_valid(lt_valid), .i_lp_ready(lp_ready), .i_lt_cancle(cancel), .i_lp_eop_en(eop_en),
    .o_tx_data_on(tx_on), .o_to_grant(to_g), .o_lt_grant(lt_g), .o_busy(busy),
    .o_state(st), .o_timeout(tmo), .o_abort(abt)
  );

  usb_tx_sched #(.IPG_CYCLES(0), .TIMEOUT_CYCLES(16), .TOK_BURST(4)) dut0 (
    .i_control_t_clk(clk), .i_control_t_rst_n(rst_n),
    .i_to_req(z_to_req), .i_lt_req(1'b0), .i_to_valid(z_to_valid), .i_to_eop(z_to_eop),
    .i_lt_valid(1'b0), .i_lp_ready(1'b0), .i_lt_cancle(1'b0), .i_lp_eop_en(1'b0),
    .o_tx_data_on(z_tx_on), .o_to_grant(z_to_g), .o_lt_grant(z_lt_g), .o_busy(z_busy),
    .o_state(z_st), .o_timeout(z_tmo), .o_abort(z_abt)
  );

  // Packed output view: {tx_on, to_grant, lt_grant, busy, state[2:0], timeout, abort}
  wire [8:0] outs = {tx_on, to_g, lt_g, busy, st, tmo, abt};

  localparam logic [8:0] E_IDLE  = 9'b0000_000_00;
  localparam logic [8:0] E_TOK   = 9'b0101_001_00;
  localparam logic [8:0] E_DATA  = 9'b1011_010_00;
  localparam logic [8:0] E_FLUSH = 9'b1001_011_01;
  localparam logic [8:0] E_GAP   = 9'b0001_100_00;

  // Inputs: {to_req, lt_req, to_valid, to_eop, lt_valid, lp_ready, cancel, eop_en}
  typedef struct packed {
    logic [7:0] in;
    logic [8:0] ex;
  } vec_t;

  vec_t tbl[$];
  int   n_chk = 0;
  int   n_fail = 0;

  task automatic check(input string nm, input int act, input int exp);
    n_chk++;
    if (act != exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", nm, act, exp);
    end
  endtask

  task automatic add(input logic [7:0] in, input logic [8:0] ex, input int n);
    for (int i = 0; i < n; i++) tbl.push_back('{in: in, ex: ex});
  endtask

  task automatic drive(input logic [7:0] in);
    {to_req, lt_req, to_valid, to_eop, lt_valid, lp_ready, cancel, eop_en} = in;
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic wait_idle(input string nm);
    int k;
    k = 0;
    while (busy && k < 40) begin
      step();
      k++;
    end
    check(nm, busy, 0);
  endtask

  initial begin
    string order;
    string exp_order;
    int    k_to;

    // Reset state
    #2;
    check("reset_outs", outs, E_IDLE);
    check("reset_outs_zero_gap", {z_tx_on, z_to_g, z_lt_g, z_busy, z_st, z_tmo, z_abt}, 0);
    @(negedge clk);
    rst_n = 1'b1;
    step();
    check("idle_after_release", outs, E_IDLE);

    // Per-cycle vector table, IPG=8
    add(8'b1100_0000, E_TOK, 1);    // both requests: token first
    add(8'b0101_0000, E_TOK, 1);    // eop without valid does not complete
    add(8'b0110_0000, E_TOK, 1);    // valid without eop does not complete
    add(8'b0111_0000, E_GAP, 1);    // token completion
    add(8'b0100_0000, E_GAP, 7);    // rest of the 8-cycle gap
    add(8'b0100_0000, E_IDLE, 1);
    add(8'b0100_0000, E_DATA, 1);   // data grant after gap + idle
    add(8'b0100_1100, E_DATA, 1);   // beat
    add(8'b0000_0011, E_FLUSH, 1);  // cancel beats eop_en
    add(8'b0000_0010, E_GAP, 8);    // cancel outside DATA ignored
    add(8'b0000_0010, E_IDLE, 2);
    add(8'b0100_0000, E_DATA, 1);
    add(8'b0000_0001, E_GAP, 1);    // normal data completion
    add(8'b0000_0000, E_GAP, 7);
    add(8'b0000_0000, E_IDLE, 1);
    foreach (tbl[i]) begin
      drive(tbl[i].in);
      step();
      check($sformatf("vec%0d", i), outs, tbl[i].ex);
    end
    drive(8'h00);

    // Starvation: both requests held, expected T,T,T,T,D,T,T,T,T,D
    exp_order = "TTTTDTTTTD";
    order = "";
    to_req = 1'b1;
    lt_req = 1'b1;
    for (int g = 0; g < 10; g++) begin
      int k;
      k = 0;
      while (!to_g && !lt_g && k < 40) begin
        step();
        k++;
      end
      if (to_g) begin
        order = {order, "T"};
        if (g == 9) begin to_req = 0; lt_req = 0; end
        to_valid = 1; to_eop = 1;
        step();
        to_valid = 0; to_eop = 0;
      end else if (lt_g) begin
        order = {order, "D"};
        if (g == 9) begin to_req = 0; lt_req = 0; end
        eop_en = 1;
        step();
        eop_en = 0;
      end else begin
        order = {order, "-"};
      end
      check($sformatf("starve_grant%0d", g), order[g], exp_order[g]);
    end
    to_req = 0;
    lt_req = 0;
    wait_idle("starve_idle");

    // Watchdog: no beats, fires 17 cycles after grant
    lt_req = 1;
    step();
    lt_req = 0;
    check("wd_grant", outs, E_DATA);
    k_to = 0;
    for (int k = 1; k <= 40; k++) begin
      step();
      if (tmo) begin k_to = k; break; end
    end
    check("wd_fire_cycle", k_to, 17);
    check("wd_fire_outs", outs, 9'b1001_011_11);
    step();
    check("wd_pulse_one_cycle", outs, E_GAP);
    wait_idle("wd_idle");

    // Watchdog restarted by a beat sampled 10 cycles after grant
    lt_req = 1;
    step();
    lt_req = 0;
    k_to = 0;
    for (int k = 1; k <= 40; k++) begin
      lt_valid = (k == 10);
      lp_ready = (k == 10);
      step();
      if (tmo) begin k_to = k; break; end
    end
    lt_valid = 0;
    lp_ready = 0;
    check("wd_restart_cycle", k_to, 27);
    wait_idle("wd_restart_idle");

    // Zero gap: completion at N -> IDLE at N+1, next grant at N+2
    z_to_req = 1;
    step();
    check("zg_grant", z_to_g, 1);
    z_to_valid = 1; z_to_eop = 1;
    step();
    z_to_valid = 0; z_to_eop = 0;
    check("zg_idle_state", z_st, 0);
    check("zg_idle_busy", z_busy, 0);
    step();
    check("zg_next_grant", {z_to_g, z_st}, {1'b1, 3'd1});
    z_to_req = 0;
    z_to_valid = 1; z_to_eop = 1;
    step();
    z_to_valid = 0; z_to_eop = 0;
    check("zg_final_idle", z_busy, 0);

    // Asynchronous reset in the middle of DATA
    lt_req = 1;
    step();
    check("rst_pre_data", outs, E_DATA);
    #2;
    rst_n = 1'b0;
    #1;
    check("rst_async_outs", outs, E_IDLE);
    lt_req = 0;
    @(negedge clk);
    rst_n = 1'b1;
    step();
    check("rst_release_idle", outs, E_IDLE);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL global_timeout: simulation did not finish, expected completion");
    $fatal(1, "timeout");
  end

endmodule
